// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event arbiter (IR remote + PS/2 keyboard).
package key_event_pkg;

  localparam logic       SRC_IR        = 1'b0;
  localparam logic       SRC_PS2       = 1'b1;
  localparam logic [7:0] IR_ASCII_BASE = 8'h30;
  localparam int         EVT_W         = 9;

  typedef struct packed {
    logic       src;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic {
    RR_IR  = 1'b0,
    RR_PS2 = 1'b1
  } rr_e;

endpackage

// File: rtl/key_event_fifo.sv
// Register-based event FIFO; extra pointer bit distinguishes full from empty.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [EVT_W-1:0] i_data,
  input  logic             i_pop,
  output logic [EVT_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Empty FIFO presents an all-zero record so outputs are defined without resetting storage.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Merges IR and PS/2 key events into one FIFO with round-robin arbitration and drop counting.
// Optional: define KEY_EVENT_IR_ASCII_EN to encode IR digits 0-9 as ASCII.
module key_event_arbiter
  import key_event_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ir_ready,
  input  logic [3:0]       ir_key,
  input  logic             ps2_pressed,
  input  logic [7:0]       ps2_code,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             evt_src,
  output logic [7:0]       evt_code,
  output logic [CNT_W-1:0] drop_cnt
);

  function automatic logic [7:0] ir_encode(input logic [3:0] key);
`ifdef KEY_EVENT_IR_ASCII_EN
    if (key <= 4'd9) return IR_ASCII_BASE + {4'h0, key};
    else             return 8'h00;
`else
    return {4'h0, key};
`endif
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) return '1;
    else            return sum[CNT_W-1:0];
  endfunction

  logic             r_ir_ready_q;
  logic             r_ir_block;
  logic             r_ir_vld;
  logic [7:0]       r_ir_code;
  logic             r_ps2_vld;
  logic [7:0]       r_ps2_code;
  rr_e              r_rr;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_ir_evt;
  logic             w_ps2_evt;
  logic             w_gnt_ir;
  logic             w_gnt_ps2;
  logic             w_ir_load;
  logic             w_ps2_load;
  logic             w_ir_drop;
  logic             w_ps2_drop;
  logic [1:0]       w_drop_inc;
  logic             w_push;
  logic [EVT_W-1:0] w_push_data;
  logic [EVT_W-1:0] w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  key_evt_t         w_push_evt;
  key_evt_t         w_head_evt;

  // r_ir_block suppresses a level that was already high across reset until it drops.
  assign w_ir_evt  = ir_ready & ~r_ir_ready_q & ~r_ir_block;
  assign w_ps2_evt = ps2_pressed;

  always_comb begin
    w_gnt_ir  = 1'b0;
    w_gnt_ps2 = 1'b0;
    if (!w_fifo_full) begin
      if (r_ir_vld && r_ps2_vld) begin
        if (r_rr == RR_IR) w_gnt_ir  = 1'b1;
        else               w_gnt_ps2 = 1'b1;
      end else if (r_ir_vld) begin
        w_gnt_ir = 1'b1;
      end else if (r_ps2_vld) begin
        w_gnt_ps2 = 1'b1;
      end
    end
  end

  // A same-cycle event on a granted source reloads the hold register instead of dropping.
  assign w_ir_load  = w_ir_evt  & (~r_ir_vld  | w_gnt_ir);
  assign w_ps2_load = w_ps2_evt & (~r_ps2_vld | w_gnt_ps2);
  assign w_ir_drop  = w_ir_evt  & r_ir_vld  & ~w_gnt_ir;
  assign w_ps2_drop = w_ps2_evt & r_ps2_vld & ~w_gnt_ps2;
  assign w_drop_inc = {1'b0, w_ir_drop} + {1'b0, w_ps2_drop};

  assign w_push          = w_gnt_ir | w_gnt_ps2;
  assign w_push_evt.src  = w_gnt_ps2 ? SRC_PS2 : SRC_IR;
  assign w_push_evt.code = w_gnt_ps2 ? r_ps2_code : r_ir_code;
  assign w_push_data     = w_push_evt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir_ready_q <= 1'b0;
      r_ir_block   <= ir_ready;
      r_ir_vld     <= 1'b0;
      r_ps2_vld    <= 1'b0;
      r_rr         <= RR_IR;
      r_drop_cnt   <= '0;
    end else begin
      r_ir_ready_q <= ir_ready;
      if (!ir_ready) r_ir_block <= 1'b0;
      r_ir_vld     <= w_ir_load  | (r_ir_vld  & ~w_gnt_ir);
      r_ps2_vld    <= w_ps2_load | (r_ps2_vld & ~w_gnt_ps2);
      // Pointer only moves on contention, so a lone grant never steals the other source's turn.
      if (r_ir_vld && r_ps2_vld && w_push) r_rr <= w_gnt_ir ? RR_PS2 : RR_IR;
      r_drop_cnt   <= sat_add(r_drop_cnt, w_drop_inc);
    end
  end

  always_ff @(posedge clock) begin
    if (w_ir_load)  r_ir_code  <= ir_encode(ir_key);
    if (w_ps2_load) r_ps2_code <= ps2_code;
  end

  key_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (evt_ready),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head_evt = w_head;
  assign evt_valid  = ~w_fifo_empty;
  assign evt_src    = w_head_evt.src;
  assign evt_code   = w_head_evt.code;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter; honours KEY_EVENT_IR_ASCII_EN for IR code expectations.
module tb_key_event_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       ir_ready;
  logic [3:0] ir_key;
  logic       ps2_pressed;
  logic [7:0] ps2_code;
  logic       evt_ready;
  logic       evt_valid;
  logic       evt_src;
  logic [7:0] evt_code;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  key_event_arbiter #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .ir_ready    (ir_ready),
    .ir_key      (ir_key),
    .ps2_pressed (ps2_pressed),
    .ps2_code    (ps2_code),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_src     (evt_src),
    .evt_code    (evt_code),
    .drop_cnt    (drop_cnt)
  );

  typedef struct {
    logic       ir_ready;
    logic [3:0] ir_key;
    logic       ps2_pressed;
    logic [7:0] ps2_code;
    logic       evt_ready;
    logic       exp_valid;
    logic       exp_src;
    logic [7:0] exp_code;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [7:0] exp_ir(input logic [3:0] k);
`ifdef KEY_EVENT_IR_ASCII_EN
    return (k <= 4'd9) ? (8'h30 + {4'h0, k}) : 8'h00;
`else
    return {4'h0, k};
`endif
  endfunction

  function automatic vec_t mk(input logic irr, input logic [3:0] key, input logic pp,
                              input logic [7:0] pc, input logic er, input logic ev,
                              input logic es, input logic [7:0] ec, input logic [7:0] ed);
    vec_t v;
    v.ir_ready = irr; v.ir_key = key; v.ps2_pressed = pp; v.ps2_code = pc;
    v.evt_ready = er; v.exp_valid = ev; v.exp_src = es; v.exp_code = ec; v.exp_drop = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int         cnt;
  int         idx;
  logic [7:0] last_code;
  logic [7:0] exp36_code [6];
  logic       exp36_src  [6];
  logic       exp36_vld  [6];

  initial begin
    reset = 1'b1; ir_ready = 1'b0; ir_key = 4'h0;
    ps2_pressed = 1'b0; ps2_code = 8'h00; evt_ready = 1'b0;

    // single IR event, then simultaneous IR+PS2 twice (round-robin)
    vecs[0]  = mk(0, 4'h0, 0, 8'h00, 1, 0, 0, 8'h00,    8'd0);
    vecs[1]  = mk(1, 4'h2, 0, 8'h00, 1, 0, 0, 8'h00,    8'd0);
    vecs[2]  = mk(1, 4'h2, 0, 8'h00, 1, 1, 0, exp_ir(2), 8'd0);
    vecs[3]  = mk(0, 4'h0, 0, 8'h00, 1, 0, 0, 8'h00,    8'd0);
    vecs[4]  = mk(0, 4'h0, 0, 8'h00, 1, 0, 0, 8'h00,    8'd0);
    vecs[5]  = mk(1, 4'h5, 1, 8'h1C, 0, 0, 0, 8'h00,    8'd0);
    vecs[6]  = mk(1, 4'h5, 0, 8'h00, 0, 1, 0, exp_ir(5), 8'd0);
    vecs[7]  = mk(0, 4'h0, 0, 8'h00, 0, 1, 0, exp_ir(5), 8'd0);
    vecs[8]  = mk(1, 4'h7, 1, 8'h2A, 1, 1, 1, 8'h1C,    8'd0);
    vecs[9]  = mk(1, 4'h7, 0, 8'h00, 1, 1, 1, 8'h2A,    8'd0);
    vecs[10] = mk(0, 4'h0, 0, 8'h00, 1, 1, 0, exp_ir(7), 8'd0);
    vecs[11] = mk(0, 4'h0, 0, 8'h00, 1, 0, 0, 8'h00,    8'd0);

    repeat (3) step();
    check("reset_valid", 32'(evt_valid), 32'd0);
    check("reset_src",   32'(evt_src),   32'd0);
    check("reset_code",  32'(evt_code),  32'd0);
    check("reset_drop",  32'(drop_cnt),  32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ir_ready = vecs[i].ir_ready; ir_key = vecs[i].ir_key;
      ps2_pressed = vecs[i].ps2_pressed; ps2_code = vecs[i].ps2_code;
      evt_ready = vecs[i].evt_ready;
      step();
      check($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_src", i),   32'(evt_src),   32'(vecs[i].exp_src));
      check($sformatf("vec%0d_code", i),  32'(evt_code),  32'(vecs[i].exp_code));
      check($sformatf("vec%0d_drop", i),  32'(drop_cnt),  32'(vecs[i].exp_drop));
    end

    // six PS2 events into a stalled depth-4 FIFO: 4 queued, 1 held, 1 dropped
    evt_ready = 1'b0; ir_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ps2_pressed = 1'b1; ps2_code = 8'(8'h10 + i);
      step();
      ps2_pressed = 1'b0;
      step(); step();
    end
    check("ovf_drop",  32'(drop_cnt), 32'd1);
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_head",  32'(evt_code), 32'h10);
    evt_ready = 1'b1;
    idx = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (evt_valid) begin
        if (idx < 5) check($sformatf("drain%0d_code", idx), 32'(evt_code), 32'(8'h10 + idx));
        idx++;
      end
    end
    check("drain_count", 32'(idx), 32'd5);
    check("drain_drop",  32'(drop_cnt), 32'd1);

    // ir_ready held high for 20 cycles yields one event
    cnt = 0; last_code = 8'hFF; ir_key = 4'h6; ir_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (evt_valid) begin cnt++; last_code = evt_code; end
    end
    ir_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (evt_valid) begin cnt++; last_code = evt_code; end
    end
    check("hold_high_count", 32'(cnt), 32'd1);
    check("hold_high_code",  32'(last_code), 32'(exp_ir(6)));

    // reset with queued events and ir_ready high
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2_pressed = 1'b1; ps2_code = 8'(8'h20 + i);
      step();
      ps2_pressed = 1'b0;
      step();
    end
    check("prerst_head", 32'(evt_code), 32'h20);
    reset = 1'b1; ir_ready = 1'b1; ir_key = 4'h9;
    step();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code",  32'(evt_code),  32'd0);
    check("rst_drop",  32'(drop_cnt),  32'd0);
    step();
    reset = 1'b0; evt_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (evt_valid) cnt++;
    end
    check("postrst_no_event", 32'(cnt), 32'd0);
    ir_ready = 1'b0;
    step();
    ir_ready = 1'b1; last_code = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      step();
      if (evt_valid) begin cnt++; last_code = evt_code; end
    end
    check("postrst_rise_count", 32'(cnt), 32'd1);
    check("postrst_rise_code",  32'(last_code), 32'(exp_ir(9)));

    // full FIFO with both holds valid, then continuous draining
    ir_ready = 1'b0; evt_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      ps2_pressed = 1'b1; ps2_code = 8'(8'h40 + i);
      step();
    end
    ps2_pressed = 1'b0;
    step(); step();
    ir_ready = 1'b1; ir_key = 4'h3; ps2_pressed = 1'b1; ps2_code = 8'h44;
    step();
    ps2_pressed = 1'b0;
    step(); step();
    check("full_valid", 32'(evt_valid), 32'd1);
    check("full_head",  32'(evt_code),  32'h40);
    check("full_drop",  32'(drop_cnt),  32'd0);
    exp36_code = '{8'h41, 8'h42, 8'h43, exp_ir(3), 8'h44, 8'h00};
    exp36_src  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp36_vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("full_drain%0d_valid", k), 32'(evt_valid), 32'(exp36_vld[k]));
      check($sformatf("full_drain%0d_src", k),   32'(evt_src),   32'(exp36_src[k]));
      check($sformatf("full_drain%0d_code", k),  32'(evt_code),  32'(exp36_code[k]));
    end
    check("full_drain_drop", 32'(drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output event FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the dropped-event counter.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ir_ready  input  1  IR decoder data-ready level; an event is its 0->1 transition.
REQ-006 SHALL have port ir_key  input  4  IR key nibble, i.e. decoder data bits [19:16], sampled on the ir_ready rising-edge cycle.
REQ-007 SHALL have port ps2_pressed  input  1  one-cycle keyboard key-pressed strobe.
REQ-008 SHALL have port ps2_code  input  8  keyboard scancode, valid with ps2_pressed.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-010 SHALL have port evt_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port evt_src  output  1  head event source: 0 = IR, 1 = PS2.
REQ-012 SHALL have port evt_code  output  8  head event code.
REQ-013 SHALL have port drop_cnt  output  CNT_W  saturating count of discarded events.

Function
REQ-014 SHALL register ir_ready once and detect a rising edge as ir_ready & ~ir_ready_q; ir_ready held high SHALL yield exactly one event.
REQ-015 SHALL keep one hold register per source (valid bit + 8-bit code); a detected event SHALL load its hold register on that clock edge.
REQ-016 SHALL discard an event whose hold register is already valid and not granted that cycle, and increment drop_cnt (saturating at all-ones).
REQ-017 SHALL grant at most one hold register per cycle into the FIFO, and only when the FIFO is not full at the start of the cycle.
REQ-018 SHALL grant the single valid source when only one is valid; when both are valid, SHALL grant round-robin (the source not granted last); IR SHALL win the first contention after reset.
REQ-019 SHALL clear a granted hold register, except that a new event from the same source in the same cycle SHALL reload it (load wins over clear; no drop).
REQ-020 SHALL pop the FIFO head when evt_valid & evt_ready; a pop and a push in the same cycle SHALL both occur, including when the FIFO is full (push refused per REQ-017, pop proceeds).
REQ-021 SHALL hold evt_src/evt_code stable while evt_valid & ~evt_ready.
REQ-022 SHALL have latency: event detected at edge N -> hold valid after N -> FIFO write at edge N+1 -> evt_valid high in cycle N+2 (FIFO empty, no contention).
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, tracking full/empty with an extra pointer bit or occupancy counter.
REQ-024 SHALL pass ps2_code unmodified as evt_code for PS2 events.

Reset
REQ-025 SHALL, while reset is high at a clock edge, clear the hold valids, FIFO pointers/occupancy, ir_ready_q, drop_cnt and the round-robin pointer (IR next), giving evt_valid=0, evt_src=0, evt_code=0, drop_cnt=0.
REQ-026 SHALL discard events presented during reset; an ir_ready level already high when reset releases SHALL NOT produce an event.

Configuration
REQ-027 SHALL, with KEY_EVENT_IR_ASCII_EN defined, encode IR events as evt_code = 8'h30 + ir_key for ir_key 0-9 and 8'h00 otherwise.
REQ-028 SHALL, without KEY_EVENT_IR_ASCII_EN, encode IR events as evt_code = {4'h0, ir_key}.

Structure
REQ-029 SHALL place SRC_IR/SRC_PS2 constants, the IR ASCII base 8'h30 and the event record typedef (src, code) in package key_event_pkg.
REQ-030 SHALL implement the FIFO as sub-module key_event_fifo (parameter FIFO_DEPTH, push/pop/full/empty).

Verification
REQ-031 SHALL test: ir_ready 0->1 with ir_key=4'h2, evt_ready=1 -> evt_valid exactly one cycle at N+2, evt_src=0, evt_code=8'h32 (ASCII on) / 8'h02 (off).
REQ-032 SHALL test: IR edge and ps2_pressed (8'h1C) on the same cycle, twice -> order IR, PS2, then PS2, IR; drop_cnt=0.
REQ-033 SHALL test: evt_ready=0, 6 PS2 events 3 cycles apart, FIFO_DEPTH=4 -> 4 queued, 1 held, 1 dropped, drop_cnt=1; then drain yields 5 codes in order.
REQ-034 SHALL test: ir_ready held high 20 cycles -> exactly one event.
REQ-035 SHALL test: reset asserted with 3 events queued and ir_ready high -> evt_valid=0 next cycle; no event after release until ir_ready falls and rises.
REQ-036 SHALL test: FIFO full, evt_ready=1 with both holds valid -> one pop per cycle, one push per cycle after first pop, codes in arbitration order.
